// File: rtl/coin_ctrl_pkg.sv
// Shared types and constants for the coin/player-control input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: coin FSM state enum, slot/input counts, count saturation value
// and a saturating adder used by the accepted-coin counter.
package coin_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        GAP      = 2'd2,
        WAIT_REL = 2'd3
    } coin_state_e;

    localparam int COIN_SLOTS  = 3;
    localparam int CTRL_INPUTS = 6;

    localparam logic [7:0] COUNT_SAT = 8'hFF;

    // The sum is formed 10 bits wide so that several coins landing on the
    // same edge near the top of the range still clamp instead of wrapping.
    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [9:0] sum;
        sum = {2'b00, cnt} + {8'h00, inc};
        return (sum > {2'b00, COUNT_SAT}) ? COUNT_SAT : sum[7:0];
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one active-low switch.
// Latency: 2+DEB_COUNT clk6m cycles from a clean raw edge to the output edge.
// Backpressure: none; level in, level out, glitches < DEB_COUNT cycles are dropped.
//
// Ports:
//   clk6m    in   system clock
//   reset    in   synchronous, active-high
//   raw_n_i  in   raw switch level, asynchronous, active low
//   deb_n_o  out  debounced level, registered, reset value 1
module input_debounce
    import coin_ctrl_pkg::*;
#(
    parameter int DEB_COUNT = 30000
) (
    input  logic clk6m,
    input  logic reset,
    input  logic raw_n_i,
    output logic deb_n_o
);

    localparam int CW = $clog2(DEB_COUNT + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter only runs while the synchronized level disagrees with the
    // accepted one; any agreement restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_COUNT - 1)) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk6m) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_n_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_n_o = deb_q;

endmodule

// File: rtl/coin_ctrl_cond.sv
// Cabinet input conditioner: merges auto-test stimuli, debounces, shapes coin pulses.
// Latency: levels 2+DEB_COUNT cycles; coin pulse starts 3+DEB_COUNT cycles after insertion.
// Backpressure: none; coins arriving during a pulse or its gap are ignored.
//
// Ports:
//   clk6m                                    in   system clock, the only clock
//   reset                                    in   synchronous, active-high
//   coin_l_n, coin_r_n, coin_aux_n           in   raw coin switches, active low
//   start1_n, start2_n, fire_n               in   raw player switches, active low
//   auto_coin_n, auto_start_n, auto_throw_n  in   synchronous auto-test stimuli
//   coin_l_o_n, coin_r_o_n, coin_aux_o_n     out  shaped coin pulses, active low
//   start1_o_n, start2_o_n, fire_o_n         out  debounced levels, active low
//   coin_count                               out  saturating accepted-coin count
module coin_ctrl_cond
    import coin_ctrl_pkg::*;
#(
    parameter int DEB_COUNT  = 30000,
    parameter int COIN_PULSE = 600000,
    parameter int COIN_GAP   = 300000
) (
    input  logic       clk6m,
    input  logic       reset,
    input  logic       coin_l_n,
    input  logic       coin_r_n,
    input  logic       coin_aux_n,
    input  logic       start1_n,
    input  logic       start2_n,
    input  logic       fire_n,
    input  logic       auto_coin_n,
    input  logic       auto_start_n,
    input  logic       auto_throw_n,
    output logic       coin_l_o_n,
    output logic       coin_r_o_n,
    output logic       coin_aux_o_n,
    output logic       start1_o_n,
    output logic       start2_o_n,
    output logic       fire_o_n,
    output logic [7:0] coin_count
);

    localparam int TMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    // Index map: 0..2 coin slots (l, r, aux), 3 start1, 4 start2, 5 fire.
    logic [CTRL_INPUTS-1:0] raw_n;
    logic [CTRL_INPUTS-1:0] deb_n;
    logic [COIN_SLOTS-1:0]  enter_pulse;
    logic [COIN_SLOTS-1:0]  coin_out_n;
    logic [1:0]             inc_num;
    logic [7:0]             count_q;
    logic [7:0]             count_d;

    // Auto-test stimuli are ANDed in ahead of the debouncer so they take
    // exactly the same path as a real switch press.
    assign raw_n[0] = coin_l_n & auto_coin_n;
    assign raw_n[1] = coin_r_n;
    assign raw_n[2] = coin_aux_n;
    assign raw_n[3] = start1_n & auto_start_n;
    assign raw_n[4] = start2_n;
    assign raw_n[5] = fire_n & auto_throw_n;

    for (genvar g = 0; g < CTRL_INPUTS; g++) begin : g_deb
        input_debounce #(
            .DEB_COUNT (DEB_COUNT)
        ) u_deb (
            .clk6m   (clk6m),
            .reset   (reset),
            .raw_n_i (raw_n[g]),
            .deb_n_o (deb_n[g])
        );
    end

    for (genvar s = 0; s < COIN_SLOTS; s++) begin : g_coin
        coin_state_e   state_q;
        logic [TW-1:0] timer_q;
        logic          out_q;

        assign enter_pulse[s] = (state_q == IDLE) && !deb_n[s];
        assign coin_out_n[s]  = out_q;

        // WAIT_REL is what turns a held switch into a single pulse: the slot
        // cannot rearm until the debounced level has gone high again.
        always_ff @(posedge clk6m) begin
            if (reset) begin
                state_q <= IDLE;
                timer_q <= '0;
                out_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!deb_n[s]) begin
                            state_q <= PULSE;
                            timer_q <= '0;
                            out_q   <= 1'b0;
                        end
                    end
                    PULSE: begin
                        if (timer_q == TW'(COIN_PULSE - 1)) begin
                            state_q <= GAP;
                            timer_q <= '0;
                            out_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (timer_q == TW'(COIN_GAP - 1)) begin
                            state_q <= WAIT_REL;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    WAIT_REL: begin
                        if (deb_n[s]) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        out_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        inc_num = '0;
        for (int i = 0; i < COIN_SLOTS; i++) begin
            inc_num = inc_num + {1'b0, enter_pulse[i]};
        end
        count_d = sat_add(count_q, inc_num);
    end

    always_ff @(posedge clk6m) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign coin_l_o_n   = coin_out_n[0];
    assign coin_r_o_n   = coin_out_n[1];
    assign coin_aux_o_n = coin_out_n[2];
    assign start1_o_n   = deb_n[3];
    assign start2_o_n   = deb_n[4];
    assign fire_o_n     = deb_n[5];
    assign coin_count   = count_q;

endmodule

// File: tb/tb_coin_ctrl_cond.sv
// Directed bench for coin_ctrl_cond with DEB_COUNT=4, COIN_PULSE=8, COIN_GAP=6.
// Timing convention: inputs change 1 ns after an edge E; a held coin shows its
// pulse low after edges E+7..E+14, debounced levels move after edge E+6.
module tb_coin_ctrl_cond;

    logic       clk6m = 1'b0;
    logic       reset = 1'b1;
    logic       coin_l_n = 1'b1, coin_r_n = 1'b1, coin_aux_n = 1'b1;
    logic       start1_n = 1'b1, start2_n = 1'b1, fire_n = 1'b1;
    logic       auto_coin_n = 1'b1, auto_start_n = 1'b1, auto_throw_n = 1'b1;
    logic       coin_l_o_n, coin_r_o_n, coin_aux_o_n;
    logic       start1_o_n, start2_o_n, fire_o_n;
    logic [7:0] coin_count;
    logic [2:0] coin_o;

    int checks = 0;
    int errors = 0;

    coin_ctrl_cond #(
        .DEB_COUNT  (4),
        .COIN_PULSE (8),
        .COIN_GAP   (6)
    ) dut (
        .clk6m        (clk6m),
        .reset        (reset),
        .coin_l_n     (coin_l_n),
        .coin_r_n     (coin_r_n),
        .coin_aux_n   (coin_aux_n),
        .start1_n     (start1_n),
        .start2_n     (start2_n),
        .fire_n       (fire_n),
        .auto_coin_n  (auto_coin_n),
        .auto_start_n (auto_start_n),
        .auto_throw_n (auto_throw_n),
        .coin_l_o_n   (coin_l_o_n),
        .coin_r_o_n   (coin_r_o_n),
        .coin_aux_o_n (coin_aux_o_n),
        .start1_o_n   (start1_o_n),
        .start2_o_n   (start2_o_n),
        .fire_o_n     (fire_o_n),
        .coin_count   (coin_count)
    );

    assign coin_o = {coin_aux_o_n, coin_r_o_n, coin_l_o_n};

    always #5 clk6m = ~clk6m;

    task automatic tick();
        @(posedge clk6m);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_levels_high(input string tag);
        check({tag, "_start1"}, {7'd0, start1_o_n}, 8'd1);
        check({tag, "_start2"}, {7'd0, start2_o_n}, 8'd1);
        check({tag, "_fire"},   {7'd0, fire_o_n},   8'd1);
    endtask

    task automatic set_coins(input logic [2:0] low_mask);
        coin_l_n   = ~low_mask[0];
        coin_r_n   = ~low_mask[1];
        coin_aux_n = ~low_mask[2];
    endtask

    // Hold the masked coins low for 'hold' cycles, checking every cycle that
    // each masked slot pulses low exactly for cycles 7..14 and that the count
    // steps from cnt0 to cnt1 on cycle 7; then release and let the FSMs rearm.
    task automatic coin_run(input string tag, input logic [2:0] mask, input int hold,
                            input logic [7:0] cnt0, input logic [7:0] cnt1);
        logic [2:0] prev;
        int         falls [3];
        logic [7:0] e;
        prev = 3'b111;
        for (int s = 0; s < 3; s++) falls[s] = 0;
        set_coins(mask);
        for (int k = 1; k <= hold; k++) begin
            tick();
            for (int s = 0; s < 3; s++) begin
                e = (mask[s] && k >= 7 && k <= 14) ? 8'd0 : 8'd1;
                check($sformatf("%s_out%0d_k%0d", tag, s, k), {7'd0, coin_o[s]}, e);
                if (prev[s] && !coin_o[s]) falls[s]++;
            end
            prev = coin_o;
            check($sformatf("%s_count_k%0d", tag, k), coin_count, (k >= 7) ? cnt1 : cnt0);
        end
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s_npulses%0d", tag, s), 8'(falls[s]), {7'd0, mask[s]});
        end
        set_coins(3'b000);
        repeat (12) tick();
    endtask

    // Silent variant used to walk the count up quickly.
    task automatic insert(input logic [2:0] mask);
        set_coins(mask);
        repeat (20) tick();
        set_coins(3'b000);
        repeat (12) tick();
    endtask

    initial begin
        logic [7:0] e;

        // Reset, then 50 idle cycles.
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            check("idle_coins", {5'd0, coin_o}, 8'h07);
            check_levels_high("idle");
            check("idle_count", coin_count, 8'd0);
        end

        // 3-cycle glitch on coin_l_n must be rejected.
        coin_l_n = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 3) coin_l_n = 1'b1;
            check("glitch_out", {5'd0, coin_o}, 8'h07);
            check("glitch_count", coin_count, 8'd0);
        end

        // Held coin_r gives one 8-cycle pulse starting 7 cycles in.
        coin_run("coin_r", 3'b010, 40, 8'd0, 8'd1);

        // Reset, then three simultaneous coins: count 0 -> 3 on one edge.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_count", coin_count, 8'd0);
        coin_run("triple", 3'b111, 25, 8'd0, 8'd3);

        // Walk the count to 254: 3 + 83*3 + 2 = 254.
        for (int r = 0; r < 83; r++) insert(3'b111);
        insert(3'b100);
        insert(3'b100);
        check("preload_254", coin_count, 8'd254);

        // 254 + 3 clamps to 255; a further coin still pulses but holds 255.
        coin_run("sat3", 3'b111, 25, 8'd254, 8'd255);
        coin_run("sat1", 3'b001, 25, 8'd255, 8'd255);

        // Auto-test throw/start and raw start2, low for 10 cycles.
        auto_throw_n = 1'b0;
        auto_start_n = 1'b0;
        start2_n     = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            e = (k >= 6 && k < 16) ? 8'd0 : 8'd1;
            check($sformatf("fire_k%0d", k),   {7'd0, fire_o_n},   e);
            check($sformatf("start1_k%0d", k), {7'd0, start1_o_n}, e);
            check($sformatf("start2_k%0d", k), {7'd0, start2_o_n}, e);
            check("lvl_coins", {5'd0, coin_o}, 8'h07);
            if (k == 10) begin
                auto_throw_n = 1'b1;
                auto_start_n = 1'b1;
                start2_n     = 1'b1;
            end
        end

        // Reset mid-pulse with coin_l_n held: pulse aborts, fresh pulse follows.
        coin_l_n = 1'b0;
        repeat (10) tick();
        check("midpulse_low", {7'd0, coin_l_o_n}, 8'd0);
        check("midpulse_count", coin_count, 8'd255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_coins", {5'd0, coin_o}, 8'h07);
        check("rst_mid_count", coin_count, 8'd0);
        check_levels_high("rst_mid");
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = (k >= 7 && k <= 14) ? 8'd0 : 8'd1;
            check($sformatf("repulse_k%0d", k), {7'd0, coin_l_o_n}, e);
            check($sformatf("repulse_cnt_k%0d", k), coin_count, (k >= 7) ? 8'd1 : 8'd0);
        end
        coin_l_n = 1'b1;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_ctrl_cond.md
Name: coin_ctrl_cond

Overview:
- Player-control input conditioner in the clk6m domain, directly downstream of the clock/reset block.
- Consumes that block's `reset` and its `auto_coin_n` / `auto_start_n` / `auto_throw_n` test stimuli, merges them with raw cabinet switches, debounces everything, and shapes each coin insertion into one fixed-width active-low pulse for the CPU switch-read logic.
- Also keeps a saturating count of accepted coins for the OSD/diagnostics.

Parameters:
- DEB_COUNT, 30000, consecutive stable clk6m cycles required to accept a level change (5 ms at 6 MHz).
- COIN_PULSE, 600000, width of each shaped coin pulse, in clk6m cycles (100 ms).
- COIN_GAP, 300000, minimum inactive cycles after a pulse before the same slot can be rearmed.

Ports:
- clk6m  in  1  pixel/system clock for this block; the only clock.
- reset  in  1  synchronous, active-high reset.
- coin_l_n, coin_r_n, coin_aux_n  in  1 each  raw coin switches, active low, asynchronous.
- start1_n, start2_n, fire_n  in  1 each  raw player switches, active low, asynchronous.
- auto_coin_n, auto_start_n, auto_throw_n  in  1 each  auto-test stimuli, active low, already clk6m-synchronous.
- coin_l_o_n, coin_r_o_n, coin_aux_o_n  out  1 each  shaped coin pulses, active low.
- start1_o_n, start2_o_n, fire_o_n  out  1 each  debounced levels, active low.
- coin_count  out  8  coins accepted since reset, saturating at 255.

Interface decision: one clock (clk6m); reset is synchronous and active-high.

Behaviour:
- Input merging (before debounce):
  - coin_l raw = coin_l_n & auto_coin_n.
  - start1 raw = start1_n & auto_start_n.
  - fire raw = fire_n & auto_throw_n.
  - All other inputs pass unmerged.
- Debouncer, one per input (6 total):
  - 2-FF synchronizer, reset value 1.
  - Stable counter: cleared whenever sync value == current debounced output; otherwise it increments.
  - When it reaches DEB_COUNT-1 while still differing, the debounced output takes the sync value and the counter clears.
  - Latency from a clean raw edge to the debounced edge is 2+DEB_COUNT cycles.
  - A glitch shorter than DEB_COUNT cycles never changes the output.
  - Counter width is $clog2(DEB_COUNT+1).
- start1_o_n, start2_o_n and fire_o_n are the debounced levels driven directly.
- Coin FSM, one per coin slot, states IDLE / PULSE / GAP / WAIT_REL:
  - IDLE: when the debounced coin is low, go to PULSE, clear the timer, drive the output low next cycle, and request a count increment.
  - PULSE: output low; after COIN_PULSE cycles in PULSE go to GAP. The pulse is exactly COIN_PULSE cycles wide.
  - GAP: output high; after COIN_GAP cycles go to WAIT_REL.
  - WAIT_REL: output high; go to IDLE once the debounced coin is high.
  - Holding a coin switch yields exactly one pulse.
  - Re-insertion during PULSE or GAP is ignored.
  - Timer width is $clog2(max(COIN_PULSE, COIN_GAP)+1).
- coin_count:
  - Adds the number of slots entering PULSE this cycle (0..3), computed 10-bit then clamped to 255.
  - At 255, further coins still pulse but the count holds.
- Reset (any cycle, including mid-pulse or mid-debounce):
  - Next edge: all outputs 1, coin_count 0, FSMs to IDLE, timers and counters 0, synchronizers 1.
  - An input held low through reset is accepted as new after 2+DEB_COUNT cycles.
  - Held coins therefore produce a pulse after reset.
- No combinational path from any input to any output.

Decomposition:
- Shared package coin_ctrl_pkg holds:
  - coin FSM state enum (2-bit: IDLE=0, PULSE=1, GAP=2, WAIT_REL=3);
  - COIN_SLOTS=3, CTRL_INPUTS=6;
  - count saturation constant 8'hFF.
- One natural sub-module: input_debounce (synchronizer + stable counter, parameter DEB_COUNT), instantiated 6×.
- Coin FSMs stay inline in a generate loop.

Test Plan (bench parameters DEB_COUNT=4, COIN_PULSE=8, COIN_GAP=6):
- Reset then idle: all outputs 1, coin_count 0, for 50 cycles.
- coin_l_n low for 3 cycles then high -> no output change, coin_count stays 0.
- coin_r_n held low for 40 cycles -> coin_r_o_n low exactly 8 cycles, starting 7 cycles after the first low sample (2 sync + 4 debounce + 1 FSM); only one pulse; coin_count=1.
- All three coins fall on the same cycle -> three simultaneous 8-cycle pulses, coin_count 0→3 on one edge. Preload the count to 254 via repeated coins -> it ends at 255 and further coins leave it at 255.
- auto_throw_n low for 10 cycles with fire_n high -> fire_o_n low from cycle 6 to cycle 16, matching the debounce latency on both edges.
- Assert reset for 1 cycle mid-pulse on coin_l_o_n -> output returns to 1 next edge and coin_count is 0. With coin_l_n still held, a fresh 8-cycle pulse follows 7 cycles after reset release.
